// File: rtl/sample_synth_pkg.sv
// Shared types and constants for the sample-based voice mixer.
package sample_synth_pkg;

  localparam int NOTE_COUNT = 128;

  typedef enum logic [1:0] {
    WAVE_SAW     = 2'd0,
    WAVE_SQUARE  = 2'd1,
    WAVE_TRI     = 2'd2,
    WAVE_SAW_ALT = 2'd3
  } wave_t;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SCAN = 1'b1
  } state_t;

endpackage

// File: rtl/sample_voice_mixer_if.sv
// Command, strobe and mix-output bundle of the voice mixer; master drives commands, slave is the mixer.
interface sample_voice_mixer_if
  import sample_synth_pkg::*;
#(
  parameter int M = 12
) ();

  logic              inSampleClockCE;
  logic [1:0]        inWaveMode;
  // Note command handshake: a command transfers on a cycle where inNoteValid && outNoteReady;
  // the master holds valid/on/index stable until then, and ready never looks at valid.
  logic              inNoteValid;
  logic              inNoteOn;
  logic [6:0]        inNoteIndex;
  logic              outNoteReady;
  logic signed [M-1:0] outSample;
  logic              outSampleValid;
  logic              outVoiceOverflow;
  logic              outCEOverrun;
  state_t            dbg_state;

  modport master (
    output inSampleClockCE, inWaveMode, inNoteValid, inNoteOn, inNoteIndex,
    input  outNoteReady, outSample, outSampleValid, outVoiceOverflow, outCEOverrun, dbg_state
  );

  modport slave (
    input  inSampleClockCE, inWaveMode, inNoteValid, inNoteOn, inNoteIndex,
    output outNoteReady, outSample, outSampleValid, outVoiceOverflow, outCEOverrun, dbg_state
  );

endinterface

// File: rtl/note_step_rom.sv
// MIDI note to phase-step lookup, table built at elaboration from equal-temperament A4 = 440 Hz.
module note_step_rom
  import sample_synth_pkg::*;
#(
  parameter int N              = 32,
  parameter int SAMPLE_RATE_HZ = 44100
) (
  input  logic [6:0]   note,
  output logic [N-1:0] step
);

  function automatic logic [N-1:0] calc_step(input int n);
    real freq;
    freq = 440.0 * (2.0 ** ((n - 69) / 12.0));
    // The real-to-integer cast rounds to nearest.
    return N'(longint'(freq * (2.0 ** N) / SAMPLE_RATE_HZ));
  endfunction

  logic [N-1:0] rom [NOTE_COUNT];

  for (genvar g = 0; g < NOTE_COUNT; g++) begin : g_rom
    localparam logic [N-1:0] STEP = calc_step(g);
    assign rom[g] = STEP;
  end

  assign step = rom[note];

endmodule

// File: rtl/sample_voice_mixer.sv
// Polyphonic phase-accumulator mixer: one voice per cycle after each sample strobe.
// Build option: SAMPLE_VOICE_MIXER_TRIANGLE_EN enables the triangle waveform for mode 2.
module sample_voice_mixer
  import sample_synth_pkg::*;
#(
  parameter int VOICES         = 4,
  parameter int N              = 32,
  parameter int M              = 12,
  parameter int SAMPLE_RATE_HZ = 44100
) (
  input logic                 inCLK,
  input logic                 inRST,
  sample_voice_mixer_if.slave bus
);

  localparam int LV = $clog2(VOICES);
  localparam int AW = M + LV;

  state_t              state;
  logic [LV-1:0]       v_idx;
  wave_t               wave_q;
  logic                voice_active [VOICES];
  logic [6:0]          voice_note   [VOICES];
  logic [N-1:0]        voice_phase  [VOICES];
  logic signed [AW-1:0] acc;
  logic signed [M-1:0] sample_q;
  logic                valid_q, overflow_q, overrun_q;

  logic                hit, free;
  logic [LV-1:0]       hit_idx, free_idx;
  logic [N-1:0]        cur_phase, step;
  logic [M-1:0]        raw;
  logic signed [M-1:0] signed_s;
  logic signed [AW-1:0] contrib, acc_next;

  note_step_rom #(.N(N), .SAMPLE_RATE_HZ(SAMPLE_RATE_HZ)) u_rom (
    .note (voice_note[v_idx]),
    .step (step)
  );

  // Descending scan so the lowest-numbered match wins.
  always_comb begin
    hit      = 1'b0;
    hit_idx  = '0;
    free     = 1'b0;
    free_idx = '0;
    for (int i = VOICES - 1; i >= 0; i--) begin
      if (!voice_active[i]) begin
        free     = 1'b1;
        free_idx = LV'(i);
      end
      if (voice_active[i] && voice_note[i] == bus.inNoteIndex) begin
        hit     = 1'b1;
        hit_idx = LV'(i);
      end
    end
  end

  assign cur_phase = voice_phase[v_idx];

  always_comb begin
    raw = '0;
    case (wave_q)
      WAVE_SQUARE: raw = {M{~cur_phase[N-1]}};
`ifdef SAMPLE_VOICE_MIXER_TRIANGLE_EN
      WAVE_TRI:    raw = cur_phase[N-1] ? ~cur_phase[N-2:N-M-1] : cur_phase[N-2:N-M-1];
`endif
      default:     raw = cur_phase[N-1:N-M];
    endcase
    signed_s = {~raw[M-1], raw[M-2:0]};
    contrib  = voice_active[v_idx] ? AW'(signed_s) : '0;
    acc_next = acc + contrib;
  end

  always_ff @(posedge inCLK) begin
    valid_q    <= 1'b0;
    overflow_q <= 1'b0;
    overrun_q  <= 1'b0;
    if (inRST) begin
      state    <= ST_IDLE;
      v_idx    <= '0;
      wave_q   <= WAVE_SAW;
      acc      <= '0;
      sample_q <= '0;
      for (int i = 0; i < VOICES; i++) begin
        voice_active[i] <= 1'b0;
        voice_note[i]   <= '0;
        voice_phase[i]  <= '0;
      end
    end else begin
      case (state)
        ST_IDLE: begin
          if (bus.inNoteValid) begin
            if (bus.inNoteOn) begin
              if (hit) begin
                voice_phase[hit_idx] <= '0;
              end else if (free) begin
                voice_active[free_idx] <= 1'b1;
                voice_note[free_idx]   <= bus.inNoteIndex;
                voice_phase[free_idx]  <= '0;
              end else begin
                overflow_q <= 1'b1;
              end
            end else if (hit) begin
              voice_active[hit_idx] <= 1'b0;
              voice_phase[hit_idx]  <= '0;
            end
          end
          // The scan reads voice registers from the next cycle on, so a same-cycle command is seen.
          if (bus.inSampleClockCE) begin
            state  <= ST_SCAN;
            v_idx  <= '0;
            acc    <= '0;
            wave_q <= wave_t'(bus.inWaveMode);
          end
        end
        ST_SCAN: begin
          if (bus.inSampleClockCE) overrun_q <= 1'b1;
          if (voice_active[v_idx]) voice_phase[v_idx] <= cur_phase + step;
          acc   <= acc_next;
          v_idx <= v_idx + 1'b1;
          if (v_idx == LV'(VOICES - 1)) begin
            state    <= ST_IDLE;
            sample_q <= M'(acc_next >>> LV);
            valid_q  <= 1'b1;
          end
        end
      endcase
    end
  end

  assign bus.outNoteReady     = (state == ST_IDLE);
  assign bus.outSample        = sample_q;
  assign bus.outSampleValid   = valid_q;
  assign bus.outVoiceOverflow = overflow_q;
  assign bus.outCEOverrun     = overrun_q;
  assign bus.dbg_state        = state;

endmodule

// File: tb/tb_sample_voice_mixer.sv
// Self-checking bench for sample_voice_mixer: note table, strobe scoreboard and reset/overrun sequences.
module tb_sample_voice_mixer;
  import sample_synth_pkg::*;

  localparam int VOICES = 4;
  localparam int N      = 32;
  localparam int M      = 12;
  localparam int SR     = 44100;
  localparam int LV     = $clog2(VOICES);

  typedef struct {
    logic       ce;
    logic       on;
    logic [6:0] note;
    logic       exp_ovf;
    int         exp_voice;
    logic       exp_active;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;
  int   valid_count = 0;
  logic rst_seen = 1'b1;
  logic [M-1:0] prev_sample = '0;

  logic [M-1:0] exp_q[$];
  int           exp_cyc_q[$];

  logic         m_active [VOICES];
  logic [6:0]   m_note   [VOICES];
  logic [N-1:0] m_phase  [VOICES];
  logic [N-1:0] m_step   [128];

  sample_voice_mixer_if #(.M(M)) bus ();

  sample_voice_mixer #(.VOICES(VOICES), .N(N), .M(M), .SAMPLE_RATE_HZ(SR)) dut (
    .inCLK (clk),
    .inRST (rst),
    .bus   (bus)
  );

  // ---------------- clock / reset bookkeeping ----------------
  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc      <= cyc + 1;
    rst_seen <= rst;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // ---------------- reference model ----------------
  task automatic model_reset();
    for (int v = 0; v < VOICES; v++) begin
      m_active[v] = 1'b0;
      m_note[v]   = '0;
      m_phase[v]  = '0;
    end
  endtask

  task automatic model_note(input logic on, input logic [6:0] nt, output logic ovf);
    int hit_v, free_v;
    hit_v  = -1;
    free_v = -1;
    for (int v = 0; v < VOICES; v++) begin
      if (m_active[v] && m_note[v] == nt && hit_v < 0) hit_v = v;
      if (!m_active[v] && free_v < 0) free_v = v;
    end
    ovf = 1'b0;
    if (on) begin
      if (hit_v >= 0) m_phase[hit_v] = '0;
      else if (free_v >= 0) begin
        m_active[free_v] = 1'b1;
        m_note[free_v]   = nt;
        m_phase[free_v]  = '0;
      end else ovf = 1'b1;
    end else if (hit_v >= 0) begin
      m_active[hit_v] = 1'b0;
      m_phase[hit_v]  = '0;
    end
  endtask

  function automatic logic [M-1:0] model_ce(input logic [1:0] mode);
    int           acc;
    logic [M-1:0] raw, t;
    logic [N-1:0] p;
    acc = 0;
    for (int v = 0; v < VOICES; v++) begin
      if (m_active[v]) begin
        p = m_phase[v];
        t = p[N-2 -: M];
        case (mode)
          2'd1: raw = p[N-1] ? {M{1'b0}} : {M{1'b1}};
`ifdef SAMPLE_VOICE_MIXER_TRIANGLE_EN
          2'd2: raw = p[N-1] ? (M'((1 << M) - 1) - t) : t;
`endif
          default: raw = p[N-1 -: M];
        endcase
        acc += int'(raw) - (1 << (M - 1));
        m_phase[v] = p + m_step[m_note[v]];
      end
    end
    return M'(acc >>> LV);
  endfunction

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin : mon
    logic [M-1:0] e;
    int           c;
    if (bus.outSampleValid) begin
      valid_count++;
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL sample_unexpected: valid pulse with value %0d but nothing expected (cycle %0d)",
                 bus.outSample, cyc);
      end else begin
        e = exp_q.pop_front();
        c = exp_cyc_q.pop_front();
        check("sample_value", 64'($unsigned(bus.outSample)), 64'(e));
        check("sample_latency", cyc, c);
      end
    end else if (!rst_seen && $unsigned(bus.outSample) !== prev_sample) begin
      checks++;
      failures++;
      $display("FAIL sample_stable: outSample moved to %0d from %0d without valid (cycle %0d)",
               bus.outSample, prev_sample, cyc);
    end
    prev_sample = $unsigned(bus.outSample);
  end

  // ---------------- driver tasks ----------------
  task automatic reset_dut();
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_sample", 64'($unsigned(bus.outSample)), 0);
    check("rst_valid", bus.outSampleValid, 0);
    check("rst_overflow", bus.outVoiceOverflow, 0);
    check("rst_overrun", bus.outCEOverrun, 0);
    check("rst_ready", bus.outNoteReady, 1);
    check("rst_state", bus.dbg_state, ST_IDLE);
    rst = 1'b0;
    model_reset();
  endtask

  task automatic send_note(input logic on, input logic [6:0] nt, output logic ovf);
    @(negedge clk);
    check("note_ready", bus.outNoteReady, 1);
    bus.inNoteValid = 1'b1;
    bus.inNoteOn    = on;
    bus.inNoteIndex = nt;
    model_note(on, nt, ovf);
    @(negedge clk);
    bus.inNoteValid = 1'b0;
  endtask

  task automatic pulse_ce(input logic [1:0] mode);
    @(negedge clk);
    bus.inSampleClockCE = 1'b1;
    bus.inWaveMode      = mode;
    exp_q.push_back(model_ce(mode));
    exp_cyc_q.push_back(cyc + VOICES + 1);
    @(negedge clk);
    bus.inSampleClockCE = 1'b0;
    bus.inWaveMode      = 2'($urandom_range(0, 3));
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL drain_timeout: %0d samples outstanding after %0d cycles", exp_q.size(), n);
      exp_q.delete();
      exp_cyc_q.delete();
    end
  endtask

  // ---------------- test sequence ----------------
  initial begin : main
    vec_t       vecs [10];
    logic       ovf;
    int         vc0;
    logic [6:0] held [VOICES];

    bus.inSampleClockCE = 1'b0;
    bus.inWaveMode      = 2'd0;
    bus.inNoteValid     = 1'b0;
    bus.inNoteOn        = 1'b0;
    bus.inNoteIndex     = '0;
    for (int n = 0; n < 128; n++)
      m_step[n] = N'(longint'(440.0 * (2.0 ** ((n - 69) / 12.0)) * (2.0 ** N) / SR));
    model_reset();

    // A4 accumulates three known steps, one valid per strobe
    reset_dut();
    send_note(1'b1, 7'd69, ovf);
    check("ovf_a4", bus.outVoiceOverflow, ovf);
    for (int i = 0; i < 3; i++) begin
      pulse_ce(2'd0);
      repeat (198) @(negedge clk);
    end
    drain();
    check("phase_v0_3ce", dut.voice_phase[0], 64'd128556843);

    // allocation, overflow, release, reuse and retrigger
    vecs[0] = '{1'b0, 1'b1, 7'd60, 1'b0, 0,  1'b1};
    vecs[1] = '{1'b0, 1'b1, 7'd61, 1'b0, 1,  1'b1};
    vecs[2] = '{1'b0, 1'b1, 7'd62, 1'b0, 2,  1'b1};
    vecs[3] = '{1'b0, 1'b1, 7'd63, 1'b0, 3,  1'b1};
    vecs[4] = '{1'b0, 1'b1, 7'd64, 1'b1, -1, 1'b0};
    vecs[5] = '{1'b1, 1'b0, 7'd0,  1'b0, -1, 1'b0};
    vecs[6] = '{1'b0, 1'b0, 7'd61, 1'b0, 1,  1'b0};
    vecs[7] = '{1'b0, 1'b1, 7'd70, 1'b0, 1,  1'b1};
    vecs[8] = '{1'b0, 1'b1, 7'd62, 1'b0, 2,  1'b1};
    vecs[9] = '{1'b1, 1'b0, 7'd0,  1'b0, -1, 1'b0};
    reset_dut();
    for (int i = 0; i < 10; i++) begin
      if (vecs[i].ce) begin
        pulse_ce(2'd0);
        drain();
      end else begin
        send_note(vecs[i].on, vecs[i].note, ovf);
        check("vec_overflow", bus.outVoiceOverflow, vecs[i].exp_ovf);
        if (vecs[i].exp_voice >= 0) begin
          check("vec_active", dut.voice_active[vecs[i].exp_voice], vecs[i].exp_active);
          check("vec_phase_zero", dut.voice_phase[vecs[i].exp_voice], 0);
          if (vecs[i].exp_active)
            check("vec_note", dut.voice_note[vecs[i].exp_voice], vecs[i].note);
        end
        if (i == 4) begin
          for (int v = 0; v < VOICES; v++) check("held_after_drop", dut.voice_note[v], 60 + v);
        end
      end
    end
    held = '{7'd60, 7'd70, 7'd62, 7'd63};
    for (int v = 0; v < VOICES; v++) begin
      check("final_note", dut.voice_note[v], held[v]);
      check("final_active", dut.voice_active[v], 1);
    end

    // strobe during a scan is reported and otherwise ignored
    vc0 = valid_count;
    pulse_ce(2'd0);
    @(negedge clk);
    bus.inSampleClockCE = 1'b1;
    @(negedge clk);
    bus.inSampleClockCE = 1'b0;
    check("ce_overrun_pulse", bus.outCEOverrun, 1);
    @(negedge clk);
    check("ce_overrun_single", bus.outCEOverrun, 0);
    drain();
    repeat (6) @(negedge clk);
    check("one_valid_per_scan", valid_count - vc0, 1);

    // square with MSB clear gives the positive full-scale share; silence gives zero
    reset_dut();
    send_note(1'b1, 7'd60, ovf);
    pulse_ce(2'd1);
    drain();
    check("square_one_voice", 64'($unsigned(bus.outSample)), 511);
    send_note(1'b0, 7'd60, ovf);
    check("off_no_overflow", bus.outVoiceOverflow, ovf);
    pulse_ce(2'd1);
    drain();
    check("all_idle_zero", 64'($unsigned(bus.outSample)), 0);

    // random high notes and modes against the model
    reset_dut();
    for (int i = 0; i < 3; i++) begin
      send_note(1'b1, 7'($urandom_range(80, 127)), ovf);
      check("rand_overflow", bus.outVoiceOverflow, ovf);
    end
    for (int i = 0; i < 10; i++) begin
      pulse_ce(2'($urandom_range(0, 3)));
      drain();
    end

    // reset in the third scan cycle aborts the scan
    vc0 = valid_count;
    @(negedge clk);
    bus.inSampleClockCE = 1'b1;
    @(negedge clk);
    bus.inSampleClockCE = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("scan_before_rst", bus.dbg_state, ST_SCAN);
    rst = 1'b1;
    @(negedge clk);
    check("abort_sample", 64'($unsigned(bus.outSample)), 0);
    check("abort_valid", bus.outSampleValid, 0);
    check("abort_overflow", bus.outVoiceOverflow, 0);
    check("abort_overrun", bus.outCEOverrun, 0);
    check("abort_ready", bus.outNoteReady, 1);
    check("abort_state", bus.dbg_state, ST_IDLE);
    for (int v = 0; v < VOICES; v++) begin
      check("abort_voice_idle", dut.voice_active[v], 0);
      check("abort_phase_zero", dut.voice_phase[v], 0);
    end
    rst = 1'b0;
    model_reset();
    repeat (10) @(negedge clk);
    check("abort_no_valid", valid_count - vc0, 0);
    check("queue_empty", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
